// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the CPU run/step controller.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } ctrl_state_e;

    localparam int unsigned DIV_DEFAULT      = 50_000_000;
    localparam int unsigned WIDTH_DEFAULT    = 36;
    localparam int unsigned CNTWIDTH_DEFAULT = 32;

    // Bits needed to hold a divider count of 0..div-1 (never less than one bit).
    function automatic int unsigned div_width(input int unsigned div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a rising-edge
// detector that emits a one-cycle event.
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic       armed_q;
    logic [1:0] fill_q;

    // NOTE: every flop here is sequential state, so only non-blocking assignments
    // are used; blocking ones would let sync_q see this edge's meta_q value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fill_q <= {fill_q[0], 1'b1};
            // Arm only after a genuinely low level has crossed the synchroniser,
            // so a button held through reset release cannot look like a press.
            if (fill_q[1] && !sync_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign rise_o = armed_q & sync_q & ~prev_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller that paces a core with one-cycle clock-enable pulses and
// captures its result. Define CPU_TICK_COUNTER_EN to build the executed-tick counter.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEFAULT,
    parameter int unsigned DIV      = DIV_DEFAULT,
    parameter int unsigned CNTWIDTH = CNTWIDTH_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                startIO,
    input  logic                stepIO,
    input  logic                stepMode,
    input  logic                coreOutFlag,
    input  logic [WIDTH-1:0]    coreOut,
    output logic                coreEn,
    output logic                outFlag,
    output logic                endFlag,
    output logic [WIDTH-1:0]    out,
    output logic [CNTWIDTH-1:0] ticks
);

    localparam int unsigned      DIV_W    = div_width(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(DIV - 2);

    logic             start_evt;
    logic             step_evt;
    ctrl_state_e      state_q;
    logic [DIV_W-1:0] div_q;
    logic             en_q;
    logic [WIDTH-1:0] out_q;
    logic             out_flag_q;
    logic             end_flag_q;

    sync_edge u_start_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (startIO),
        .rise_o  (start_evt)
    );

    sync_edge u_step_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (stepIO),
        .rise_o  (step_evt)
    );

    // en_q is registered, so it is set one cycle ahead: in RUN when the divider
    // is about to reach DIV-1, in STEP on the cycle carrying the step event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            en_q       <= 1'b0;
            out_q      <= '0;
            out_flag_q <= 1'b0;
            end_flag_q <= 1'b0;
        end else begin
            en_q <= 1'b0;
            if ((state_q == RUN || state_q == STEP) && coreOutFlag) begin
                out_q      <= coreOut;
                out_flag_q <= 1'b1;
                end_flag_q <= 1'b1;
                state_q    <= DONE;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start_evt) begin
                            state_q    <= stepMode ? STEP : RUN;
                            div_q      <= '0;
                            out_flag_q <= 1'b0;
                            end_flag_q <= 1'b0;
                        end
                    end
                    RUN: begin
                        div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                        en_q  <= (div_q == DIV_PRE);
                    end
                    STEP: begin
                        en_q <= step_evt;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CPU_TICK_COUNTER_EN
    logic [CNTWIDTH-1:0] ticks_q;
    logic [CNTWIDTH-1:0] ticks_d;

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        ticks_d = ticks_q;
        if (start_evt && (state_q == IDLE || state_q == DONE)) begin
            ticks_d = '0;
        end else if (en_q && (ticks_q != '1)) begin
            ticks_d = ticks_q + CNTWIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ticks_q <= '0;
        end else begin
            ticks_q <= ticks_d;
        end
    end

    assign ticks = ticks_q;
`else
    assign ticks = '0;
`endif

    assign coreEn  = en_q;
    assign outFlag = out_flag_q;
    assign endFlag = end_flag_q;
    assign out     = out_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus predicts each coreEn pulse (cycle and
// tick count) from the timing rules, and a monitor matches the pulses the DUT emits.
module tb_cpu_run_ctrl;

    localparam int DIV = 4;
    localparam int W   = 36;

    logic         clock       = 1'b0;
    logic         reset       = 1'b0;
    logic         startIO     = 1'b0;
    logic         stepIO      = 1'b0;
    logic         stepMode    = 1'b0;
    logic         coreOutFlag = 1'b0;
    logic [W-1:0] coreOut     = '0;

    logic         coreEn, outFlag, endFlag;
    logic [W-1:0] out;
    logic [31:0]  ticks;
    logic         coreEn3, outFlag3, endFlag3;
    logic [W-1:0] out3;
    logic [2:0]   ticks3;

    typedef struct {
        int cyc;
        int n;
    } pulse_t;

    pulse_t sb[$];
    int     cyc      = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    cpu_run_ctrl #(.WIDTH(W), .DIV(DIV), .CNTWIDTH(32)) dut (
        .clock(clock), .reset(reset), .startIO(startIO), .stepIO(stepIO),
        .stepMode(stepMode), .coreOutFlag(coreOutFlag), .coreOut(coreOut),
        .coreEn(coreEn), .outFlag(outFlag), .endFlag(endFlag), .out(out), .ticks(ticks)
    );

    cpu_run_ctrl #(.WIDTH(W), .DIV(DIV), .CNTWIDTH(3)) dut3 (
        .clock(clock), .reset(reset), .startIO(startIO), .stepIO(stepIO),
        .stepMode(stepMode), .coreOutFlag(coreOutFlag), .coreOut(coreOut),
        .coreEn(coreEn3), .outFlag(outFlag3), .endFlag(endFlag3), .out(out3), .ticks(ticks3)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected tick count after n pulses for a counter w bits wide.
    function automatic longint unsigned exp_ticks(input int n, input int w);
`ifdef CPU_TICK_COUNTER_EN
        longint unsigned m;
        m = (64'd1 << w) - 64'd1;
        return (longint'(n) > m) ? m : longint'(n);
`else
        return 0;
`endif
    endfunction

    always @(negedge clock) begin : monitor
        pulse_t e;
        if (coreEn || coreEn3) begin
            if (sb.size() == 0) begin
                check("spurious_coreEn", {62'd0, coreEn, coreEn3}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_both_duts", {62'd0, coreEn, coreEn3}, 64'd3);
                check("ticks_at_pulse", ticks, exp_ticks(e.n, 32));
                check("ticks3_at_pulse", ticks3, exp_ticks(e.n, 3));
            end
        end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            e = sb.pop_front();
            check("missed_pulse", cyc, e.cyc);
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Start press: synchroniser (2) + edge detect + state register put the first
    // free-run pulse DIV+2 cycles after the press, then one every DIV cycles.
    task automatic start_run(input logic mode, input int n_pulses, output int c);
        c        = cyc;
        stepMode = mode;
        for (int i = 0; i < n_pulses; i++) sb.push_back('{c + DIV + 2 + i * DIV, i});
        startIO = 1'b1;
        repeat (4) @(negedge clock);
        startIO = 1'b0;
    endtask

    // Step press: its pulse lands three cycles after the press.
    task automatic press_step(input int idx, input bit expect_pulse);
        if (expect_pulse) sb.push_back('{cyc + 3, idx});
        stepIO = 1'b1;
        repeat (1 + $urandom_range(2)) @(negedge clock);
        stepIO = 1'b0;
        repeat (3 + $urandom_range(3)) @(negedge clock);
    endtask

    task automatic capture(input logic [W-1:0] val, input int n);
        coreOut     = val;
        coreOutFlag = 1'b1;
        @(negedge clock);
        coreOutFlag = 1'b0;
        check("cap_out", out, val);
        check("cap_outFlag", outFlag, 1);
        check("cap_endFlag", endFlag, 1);
        check("cap_ticks", ticks, exp_ticks(n, 32));
        check("cap_out3", out3, val);
        check("cap_endFlag3", endFlag3, 1);
        check("cap_ticks3", ticks3, exp_ticks(n, 3));
        coreOut = W'({$urandom(), $urandom()});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           c;
        int           n;
        int           off;
        logic [W-1:0] val;

        repeat (2) @(negedge clock);
        check("rst_coreEn", coreEn, 0);
        check("rst_outFlag", outFlag, 0);
        check("rst_endFlag", endFlag, 0);
        check("rst_out", out, 0);
        check("rst_ticks", ticks, 0);
        reset = 1'b1;
        repeat (6) @(negedge clock);

        // Step presses in IDLE must not produce pulses.
        for (int i = 0; i < 3; i++) press_step(0, 1'b0);
        check("idle_ticks", ticks, 0);
        check("idle_endFlag", endFlag, 0);

        // Free run, result flag raised in the same cycle as the third pulse.
        start_run(1'b0, 3, c);
        wait_cyc(c + DIV + 2 + 2 * DIV);
        capture(36'h0_0000_00AB, 3);
        repeat (3 * DIV) @(negedge clock);
        check("done_hold_out", out, 36'h0_0000_00AB);
        check("done_hold_ticks", ticks, exp_ticks(3, 32));
        check("done_hold_endFlag", endFlag, 1);

        // Restart from DONE in step mode.
        start_run(1'b1, 0, c);
        check("restart_outFlag", outFlag, 0);
        check("restart_endFlag", endFlag, 0);
        check("restart_ticks", ticks, 0);
        repeat (4) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            press_step(i, 1'b1);
            stepMode = 1'($urandom_range(1));
            if (i == 2) begin
                startIO = 1'b1;
                repeat (4) @(negedge clock);
                startIO = 1'b0;
                repeat (4) @(negedge clock);
            end
        end
        check("step_ticks", ticks, exp_ticks(5, 32));
        check("step_ticks3", ticks3, exp_ticks(5, 3));
        val = W'({$urandom(), $urandom()}) | W'(1);
        capture(val, 5);
        for (int i = 0; i < 2; i++) press_step(0, 1'b0);
        check("done_step_ticks", ticks, exp_ticks(5, 32));
        check("done_step_out", out, val);

        // Randomised free runs; the first one drives the 3-bit counter past saturation.
        for (int r = 0; r < 3; r++) begin
            n   = (r == 0) ? 9 : int'($urandom_range(8, 2));
            off = int'($urandom_range(DIV - 2));
            val = W'({$urandom(), $urandom()}) | W'(1);
            repeat (4) @(negedge clock);
            start_run(1'b0, n, c);
            wait_cyc(c + DIV + 2 + (n - 1) * DIV + off);
            capture(val, n);
        end

        // Reset asserted in the cycle of the eighth pulse, start held high throughout.
        repeat (4) @(negedge clock);
        start_run(1'b0, 8, c);
        wait_cyc(c + DIV + 2 + 7 * DIV);
        check("pre_reset_ticks", ticks, exp_ticks(7, 32));
        startIO = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_coreEn", coreEn, 0);
        check("mid_rst_coreEn3", coreEn3, 0);
        check("mid_rst_outFlag", outFlag, 0);
        check("mid_rst_endFlag", endFlag, 0);
        check("mid_rst_out", out, 0);
        check("mid_rst_ticks", ticks, 0);
        check("mid_rst_ticks3", ticks3, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check("post_rst_ticks", ticks, 0);
        check("post_rst_endFlag", endFlag, 0);
        check("post_rst_out", out, 0);
        startIO = 1'b0;
        repeat (6) @(negedge clock);

        // A normal run after reset shows the start button is live again.
        val = W'({$urandom(), $urandom()}) | W'(1);
        start_run(1'b0, 2, c);
        wait_cyc(c + DIV + 2 + DIV);
        capture(val, 2);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
